// File: rtl/serial_tx_arb_pkg.sv
// Shared types and helpers for the round-robin serial transmit arbiter.
// Holds the FSM encoding, the counter-width helper and the parity function.
package serial_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    GAP
  } fsm_t;

  // Widest word the parity helper folds; callers zero-extend.
  localparam int MAX_PAR_W = 64;

  // Counter wide enough to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic even_parity(
    input logic [MAX_PAR_W-1:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches from last_grant+1, wrapping.
// Ports: req_valid, last_grant in; one-hot grant, grant_idx, grant_any out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_any
);

  localparam int IW = $clog2(NUM_REQ);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one LSB-first serial shifter between NUM_REQ word sources.
// Ports: req_valid/req_data/req_ready per source; rdy/dout/dout_valid/
// dout_first/dout_last/dout_src serial lane; busy status.
// Option: SERIAL_TX_ARB_PARITY_EN appends an even-parity bit per frame.
module serial_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            rdy,
  output logic                            dout,
  output logic                            dout_valid,
  output logic                            dout_first,
  output logic                            dout_last,
  output logic [$clog2(NUM_REQ)-1:0]      dout_src,
  output logic                            busy
);

  import serial_tx_arb_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam fsm_t AFTER_FRAME =
    (GAP_CYCLES > 0) ? GAP : IDLE;

  fsm_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  par_q, par_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [IW-1:0]         dout_src_q, dout_src_d;
  logic                  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_first_q, dout_first_d;
  logic                  dout_last_q, dout_last_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] word;
  logic                  last_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign word =
    req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign last_data = (cnt_q == CW'(DATA_WIDTH - 1));

  // Grant always targets a valid source, so ready alone implies transfer.
  assign req_ready =
    (state_q == IDLE && !reset) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    par_d        = par_q;
    last_grant_d = last_grant_q;
    dout_src_d   = dout_src_q;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          shreg_d      = word;
          par_d        = even_parity(MAX_PAR_W'(word));
          last_grant_d = grant_idx;
          dout_src_d   = grant_idx;
          cnt_d        = '0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        if (rdy) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (last_data) begin
            gap_d = '0;
`ifdef SERIAL_TX_ARB_PARITY_EN
            state_d = PARITY;
`else
            state_d = AFTER_FRAME;
`endif
          end
        end
      end
      PARITY: begin
        if (rdy) begin
          gap_d   = '0;
          state_d = AFTER_FRAME;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so bit 0
    // appears the cycle after the accept.
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    dout_first_d = 1'b0;
    dout_last_d  = 1'b0;
    busy_d       = (state_d != IDLE);
    if (state_d == SHIFT) begin
      dout_d       = shreg_d[0];
      dout_valid_d = 1'b1;
      dout_first_d = (cnt_d == '0);
`ifdef SERIAL_TX_ARB_PARITY_EN
      dout_last_d  = 1'b0;
`else
      dout_last_d  = (cnt_d == CW'(DATA_WIDTH - 1));
`endif
    end else if (state_d == PARITY) begin
      dout_d       = par_d;
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      par_q        <= 1'b0;
      last_grant_q <= IW'(NUM_REQ - 1);
      dout_src_q   <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      par_q        <= par_d;
      last_grant_q <= last_grant_d;
      dout_src_q   <= dout_src_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_first = dout_first_q;
  assign dout_last  = dout_last_q;
  assign dout_src   = dout_src_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter against a frame-queue model.
// Directed plan items first, then randomized valid/rdy/reset traffic.
module tb_serial_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int GAP = 0;
  localparam int IW  = $clog2(N);
`ifdef SERIAL_TX_ARB_PARITY_EN
  localparam int FL  = DW + 1;
`else
  localparam int FL  = DW;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rdy;
  logic            dout, dout_valid, dout_first, dout_last;
  logic [IW-1:0]   dout_src;
  logic            busy;

  serial_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rdy        (rdy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_first (dout_first),
    .dout_last  (dout_last),
    .dout_src   (dout_src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame still to be sent, as a bit queue.
  bit mq[$];
  int m_gap   = 0;
  int m_ptr   = N - 1;
  int m_src   = 0;
  int m_taken = 0;
  int m_acc   = -1;
  int cyc     = 0;

  logic         s_dout, s_dv, s_first, s_last;
  logic [N-1:0] s_ready;
  int           s_cyc;

  function automatic bit m_idle();
    return (mq.size() == 0) && (m_gap == 0);
  endfunction

  function automatic int model_grant();
    int i;
    if (reset || !m_idle()) return -1;
    for (int k = 1; k <= N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    logic [DW-1:0] w;
    m_acc = -1;
    if (reset) begin
      mq.delete();
      m_gap = 0;
      m_ptr = N - 1;
      m_src = 0;
    end else if (m_idle()) begin
      g = model_grant();
      if (g >= 0) begin
        w = req_data[g*DW +: DW];
        for (int b = 0; b < DW; b++) mq.push_back(w[b]);
`ifdef SERIAL_TX_ARB_PARITY_EN
        mq.push_back(^w);
`endif
        m_src = g;
        m_ptr = g;
        m_taken = 0;
        m_acc = g;
      end
    end else if (mq.size() > 0) begin
      if (rdy) begin
        void'(mq.pop_front());
        m_taken++;
        if (mq.size() == 0) m_gap = GAP;
      end
    end else begin
      m_gap--;
    end
  endtask

  task automatic tick();
    logic [N-1:0] er;
    bit           ev;
    int           g;
    @(negedge clk);
    s_dout  = dout;
    s_dv    = dout_valid;
    s_first = dout_first;
    s_last  = dout_last;
    s_ready = req_ready;
    s_cyc   = cyc;
    ev = (mq.size() > 0);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("ready", 32'(req_ready), 32'(er));
    check("valid", 32'(dout_valid), 32'(ev));
    check("first", 32'(dout_first),
          32'(ev && m_taken == 0));
    check("last", 32'(dout_last),
          32'(ev && mq.size() == 1));
    check("src", 32'(dout_src), 32'(m_src));
    check("busy", 32'(busy), 32'(!m_idle()));
    if (ev) check("dout", 32'(dout), 32'(mq[0]));
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic wait_accept(input int src);
    int n = 0;
    while (m_acc != src && n < 100) begin
      tick();
      n++;
    end
    if (m_acc != src) check("acc_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    rdy = 1'b1;
    while (!m_idle() && n < 200) begin
      tick();
      n++;
    end
    check("drain_idle", 32'(m_idle()), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int            acc_order[$];
  int            acc_cyc[$];
  int            t_acc, t_end, taken, stall;
  logic [15:0]   pat;

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    rdy       = 1'b1;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = DW'($urandom);
    repeat (2) @(posedge clk);
    #1;

    // Reset values with every source requesting
    repeat (3) tick();
    check("rst_dout", 32'(s_dout), 0);
    check("rst_ready", 32'(s_ready), 0);

    // Round-robin from the reset pointer, all sources valid
    reset = 1'b0;
    for (int n = 0; n < 200 && acc_order.size() < 5; n++) begin
      tick();
      if (acc_order.size() == 0 && n == 0)
        check("first_grant", 32'(s_ready), 32'h1);
      if (m_acc >= 0) begin
        acc_order.push_back(m_acc);
        acc_cyc.push_back(s_cyc);
        req_data[m_acc*DW +: DW] = DW'($urandom);
      end
    end
    check("rr_count", acc_order.size(), 5);
    for (int k = 0; k < acc_order.size(); k++) begin
      check("rr_order", acc_order[k], k % N);
      if (k > 0)
        check("rr_spacing", acc_cyc[k] - acc_cyc[k-1],
              FL + GAP + 1);
    end
    drain();

    // Single word 16'hA5C3 from source 0
    do_reset();
    pat = 16'hA5C3;
    req_data[0 +: DW] = DW'(pat);
    req_valid = 4'b0001;
    wait_accept(0);
    req_valid = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("a5c3_bit", 32'(s_dout), 32'(pat[k]));
      check("a5c3_dv", 32'(s_dv), 1);
      check("a5c3_first", 32'(s_first), 32'(k == 0));
      if (FL == 16)
        check("a5c3_last", 32'(s_last), 32'(k == 15));
    end
    check("a5c3_src", 32'(dout_src), 0);
    drain();

    // Stall of 3 cycles while bit 5 is presented
    req_data[3*DW +: DW] = DW'($urandom);
    req_valid = 4'b1000;
    wait_accept(3);
    req_valid = '0;
    t_acc = s_cyc;
    t_end = -1;
    taken = 0;
    stall = 3;
    for (int n = 0; n < 100 && t_end < 0; n++) begin
      if (taken == 5 && stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = 1'b1;
      end
      tick();
      if (s_dv && rdy) begin
        if (s_last) t_end = s_cyc;
        taken++;
      end
    end
    check("stall_end", t_end - t_acc, FL + 3);
    drain();

    // Reset while bit 8 of source 2 is presented
    req_data[2*DW +: DW] = DW'($urandom);
    req_valid = 4'b0100;
    wait_accept(2);
    req_valid = '0;
    repeat (8) tick();
    reset = 1'b1;
    req_valid = 4'b1010;
    tick();
    check("midrst_bit8_dv", 32'(s_dv), 1);
    reset = 1'b0;
    tick();
    check("midrst_dv", 32'(s_dv), 0);
    check("midrst_grant", 32'(s_ready), 32'h2);
    drain();

`ifdef SERIAL_TX_ARB_PARITY_EN
    // Parity bit is the 17th bit and the final one
    for (int p = 0; p < 2; p++) begin
      req_data[0 +: DW] = (p == 0) ? DW'(1) : DW'(3);
      req_valid = 4'b0001;
      wait_accept(0);
      req_valid = '0;
      repeat (17) tick();
      check("par_bit", 32'(s_dout), (p == 0) ? 1 : 0);
      check("par_last", 32'(s_last), 1);
      drain();
    end
`endif

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_acc == i) begin
          req_valid[i] = 1'($urandom % 2);
          req_data[i*DW +: DW] = DW'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom % 16 == 0) req_valid[i] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      rdy   = ($urandom % 4) != 0;
      reset = ($urandom % 600) == 0;
    end
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin controller that shares one LSB-first parallel-to-serial shifter between `NUM_REQ` word sources. Each source offers a parallel word with a valid/ready handshake. The controller grants one source at a time, loads its word into the shifter and counts the bits out under downstream `rdy` flow control. It sits between the word-producing blocks and the single serial output lane.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 16: bits per word, ≥2.
- `GAP_CYCLES`, 0: extra idle cycles inserted after each frame.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-source word-valid.
- `req_data` in NUM_REQ*DATA_WIDTH: flat words; source i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out NUM_REQ: one-hot accept, combinational.
- `rdy` in 1: downstream takes the current bit this cycle.
- `dout` out 1: serial bit.
- `dout_valid` out 1: `dout` is a frame bit.
- `dout_first` out 1: current bit is frame bit 0.
- `dout_last` out 1: current bit is the final frame bit.
- `dout_src` out $clog2(NUM_REQ): index of the source being shifted.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, SHIFT, PARITY, GAP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first asserted `req_valid` searching from `last_grant+1`, wrapping.
  - `req_ready[grant]`=1; all other ready bits are 0. No ready bit is asserted outside IDLE.
  - Transfer occurs when `req_valid[g] & req_ready[g]`. On transfer: capture the word into the shift register, set `last_grant`=g and `dout_src`=g, clear the bit counter, go to SHIFT.
- **SHIFT**
  - `dout`=shreg[0] and `dout_valid`=1.
  - A bit is taken when `dout_valid & rdy`. On a take: shreg shifts right and the counter increments.
  - On the take of bit `DATA_WIDTH-1`, go to PARITY (macro on), else GAP if `GAP_CYCLES`>0, else IDLE.
- **PARITY**: presents the even-parity bit until it is taken, then goes to GAP or IDLE.
- **GAP**: `dout_valid`=0 for `GAP_CYCLES` cycles, then IDLE.
- `dout_first` is 1 only while bit 0 is presented.
- `dout_last` is 1 while the final frame bit is presented: data bit `DATA_WIDTH-1`, or the parity bit when the macro is on.
- Requesters hold `req_data` stable while valid until accepted. A source may drop `req_valid` before it is granted.
- The bit counter is $clog2(DATA_WIDTH+1) wide and does not wrap mid-frame.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `dout_first`=0, `dout_last`=0, `dout_src`=0, `busy`=0, `req_ready`=0 during reset, `last_grant`=NUM_REQ-1, so source 0 wins first.
- All outputs except `req_ready` are registered.
- Accept at cycle T → bit 0 is on `dout` at T+1.
- With `rdy` held at 1, the last data bit appears at T+DATA_WIDTH.
- Inter-frame gap with `dout_valid`=0 is 1+GAP_CYCLES cycles (IDLE plus GAP).
- `rdy`=0 holds `dout`, `dout_valid`, `dout_first` and `dout_last` stable. Stalls can be of unlimited length.
- `reset` mid-frame: the next cycle shows reset values and the in-flight word is dropped, with no partial-frame flush.
- Simultaneous requests resolve by round-robin only, with no fixed priority beyond the reset pointer.

## Configuration
- `SERIAL_TX_ARB_PARITY_EN`
  - Defined: the PARITY state exists, frames are DATA_WIDTH+1 bits, and the final bit = XOR of the data word (even parity).
  - Undefined: the PARITY state is absent and frames are DATA_WIDTH bits.

## Structure
- Package `serial_tx_arb_pkg` holds:
  - `fsm_t` enum {IDLE, SHIFT, PARITY, GAP};
  - localparam helper for counter width;
  - parity function.
- Sub-module `rr_arbiter` (NUM_REQ param): a combinational grant from `req_valid` and the `last_grant` pointer. Outputs are a one-hot grant and an encoded index.
- The shift register, counter and FSM stay in the top module.

## Test plan
- **Reset values**: hold `reset` 3 cycles with `req_valid`=4'b1111 → all outputs 0, `req_ready`=0; first grant after release goes to source 0.
- **Single word**: source 0 offers 16'hA5C3 and is accepted at T, `rdy`=1.
  - `dout` at T+1..T+16 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `dout_first` is 1 at T+1 and `dout_last` is 1 at T+16.
  - `dout_src`=0.
- **Round-robin**: all four sources valid continuously → grant order 0,1,2,3,0, each frame 16 bits with a 1-cycle gap (`GAP_CYCLES`=0).
- **Stall**: `rdy`=0 for 3 cycles while bit 5 is presented → `dout` and `dout_valid` are held stable and the frame ends 3 cycles later than unstalled.
- **Reset mid-frame**: reset during bit 8 of source 2, then sources 1 and 3 valid → `dout_valid`=0 the next cycle; source 1 is granted after release.
- **Parity (macro defined)**:
  - 16'h0001 → 17th bit 1 with `dout_last`=1.
  - 16'h0003 → 17th bit 0.
  - `GAP_CYCLES`=2 gives 3 idle cycles between frames.
